// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for a 640x480 @ 60 Hz display (800x525 total).
//   Runs on the system clock and advances the raster counters once every
//   CLK_DIV clocks. All decoded outputs are registered from the next counter
//   values, so they change on the same edge as hCount/vCount.
//
//   Optional feature (macro VGA_TIMING_FRAME_COUNT_EN):
//     adds an 8-bit frame_count output, incremented on each frame_start.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   hCount[9:0]  out  horizontal pixel counter, 0..H_TOTAL-1
//   vCount[9:0]  out  vertical line counter, 0..V_TOTAL-1
//   hSync        out  horizontal sync, active low
//   vSync        out  vertical sync, active low
//   bright       out  high inside the visible window
//   pixel_tick   out  one-clk pulse on the clk where the counters advanced
//   frame_start  out  one-clk pulse when the counters wrap to (0,0)
//   frame_count  out  frames elapsed, mod 256 (VGA_TIMING_FRAME_COUNT_EN only)
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_SYNC      = 96,
    parameter int V_SYNC      = 2,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pixel_tick,
    output logic       frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_C  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_C  = 10'(V_SYNC);
    localparam logic [9:0] H_VS_C    = 10'(H_VIS_START);
    localparam logic [9:0] H_VE_C    = 10'(H_VIS_END);
    localparam logic [9:0] V_VS_C    = 10'(V_VIS_START);
    localparam logic [9:0] V_VE_C    = 10'(V_VIS_END);

    logic [3:0] div;
    logic       adv;
    logic       frame_wrap;
    logic [9:0] h_next;
    logic [9:0] v_next;

    // Counters advance on the clk where the divider sits at its last value,
    // so the first advance after reset lands on the CLK_DIV-th edge.
    assign adv        = (div == DIV_LAST);
    assign frame_wrap = (hCount == H_LAST) && (vCount == V_LAST);

    always_comb begin
        h_next = hCount;
        v_next = vCount;
        if (hCount == H_LAST) begin
            h_next = '0;
            if (vCount == V_LAST) begin
                v_next = '0;
            end else begin
                v_next = vCount + 10'd1;
            end
        end else begin
            h_next = hCount + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= '0;
            hCount      <= '0;
            vCount      <= '0;
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            bright      <= 1'b0;
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= adv ? '0 : div + 4'd1;
            pixel_tick  <= adv;
            frame_start <= adv && frame_wrap;
            if (adv) begin
                hCount <= h_next;
                vCount <= v_next;
                // Decode from next values so sync/bright stay aligned with the counters.
                hSync  <= (h_next >= H_SYNC_C);
                vSync  <= (v_next >= V_SYNC_C);
                bright <= (h_next >= H_VS_C) && (h_next < H_VE_C) &&
                          (v_next >= V_VS_C) && (v_next < V_VE_C);
            end
        end
    end

`ifdef VGA_TIMING_FRAME_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= '0;
        end else if (adv && frame_wrap) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

endmodule
